branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Counterpart of the ID-stage branch predictor. Tracks predictions from ID to MEM and checks each against the resolved outcome.
//  Sends the 2-bit counter training update (valid/pc/taken) back to the predictor.
//  On a wrong prediction, issues a one-cycle fetch redirect and squashes younger in-flight predictions.
//  Sits between ID (push side), MEM (resolve side), the predictor update port and the PC-select/flush logic.
// PARAMETERS
//  DEPTH       4   in-flight prediction FIFO entries; power of two, 2..8
//  RECOVER_CYC 2   cycles after a redirect during which ID pushes are ignored (wrong-path drain)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous active-high reset
//  id_push        in   1   ID holds a conditional branch and is advancing; record prediction
//  id_pc          in   32  PC of that branch
//  id_bp_result   in   1   predicted taken
//  id_bp_addr     in   32  predicted target
//  mem_resolve    in   1   MEM holds a resolved conditional branch (one pulse per branch)
//  mem_pc         in   32  PC of resolved branch
//  mem_taken      in   1   actual direction
//  mem_target     in   32  actual taken target
//  bru_full       out  1   FIFO full; ID must stall branch issue
//  upd_valid      out  1   predictor training strobe
//  upd_pc         out  32  PC to train
//  upd_taken      out  1   actual outcome to train with
//  redirect_valid out  1   one-cycle pulse: flush younger stages, load redirect_pc
//  redirect_pc    out  32  correct fetch PC
//  branch_cnt     out  32  resolved branches, wraps
//  mispred_cnt    out  32  mispredictions, wraps
//  err_sticky     out  1   PC mismatch or overflow seen; cleared only by reset
// BEHAVIOUR
//  Reset: FIFO empty, FSM=RUN, all outputs 0, counters 0, err_sticky 0.
//  FIFO record: {pc, pred_taken, pred_target}. bru_full is combinational = (count==DEPTH).
//  Push: id_push & FSM==RUN. If full: drop the record and set err_sticky.
//  Pop: every mem_resolve pops the head.
//   - If empty: treat as predicted not-taken, target 0.
//   - If head.pc!=mem_pc: set err_sticky and still compare against the head.
//  Simultaneous push+pop: count unchanged.
//   - Pop on empty + push: enqueue only.
//   - Push on full + pop: accepted (a slot frees the same cycle).
//  Mispredict = (mem_taken!=pred_taken) | (mem_taken & pred_taken & mem_target!=pred_target).
//  Correct PC: mem_taken ? mem_target : mem_pc+8 (delay slot already fetched). Add is 32-bit and wraps.
//  Latency: all outputs registered, 1 cycle after mem_resolve.
//   - upd_valid=1, upd_pc=mem_pc, upd_taken=mem_taken for every resolve.
//   - branch_cnt+1.
//   - On mispredict also: redirect_valid=1, redirect_pc=correct PC, mispred_cnt+1.
//  Mispredict resets the FIFO to empty in the same edge that registers the redirect. Any same-cycle push is discarded.
//  FSM:
//   - RUN -> RECOVER on mispredict.
//   - RECOVER counts RECOVER_CYC cycles, then -> RUN. Pushes are ignored in RECOVER.
//   - mem_resolve in RECOVER: still trains the predictor; compares against an empty FIFO (not-taken rule).
//   - A further mispredict in RECOVER restarts the count and redirects again.
//  redirect_valid and upd_valid are single-cycle pulses; redirect_pc/upd_pc hold their last value when not strobed.
//  Reset asserted mid-operation: everything returns to reset values on that edge; no redirect is emitted.
// STRUCTURE
//  Shared package:
//   - FIFO record typedef (pc, pred_taken, pred_target).
//   - FSM state enum (RUN, RECOVER).
//   - DELAY_SLOT_OFS = 32'd8.
//  One sub-module: bru_pred_fifo.
//   - Synchronous DEPTH-entry FIFO with push/pop/clear.
//   - Outputs full/empty/head.
//   - Pointer wrap uses an extra MSB.
//  Top level holds the compare, FSM, counters and output registers.
// TESTING
//  1 Push pc=0x100 pred T tgt=0x200; resolve pc=0x100 T tgt=0x200 -> next cycle upd_valid=1, upd_taken=1; no redirect; branch_cnt=1.
//  2 Push pc=0x100 pred NT; resolve taken tgt=0x300 -> redirect_valid=1, redirect_pc=0x300, mispred_cnt=1; FIFO empty; pushes ignored 2 cycles.
//  3 Push pred T tgt=0x200; resolve NT pc=0x100 -> redirect_pc=0x108; also a wrong-target case: pred T 0x200, actual T 0x204 -> redirect_pc=0x204.
//  4 Push 4 entries -> bru_full=1; 5th push alone -> dropped, err_sticky=1; 5th push with same-cycle resolve -> accepted, count stays 4.
//  5 Resolve on empty FIFO, taken tgt=0x40 -> redirect_pc=0x40; not-taken pc=0xFFFFFFFC -> no redirect, upd_pc=0xFFFFFFFC.
//  6 Reset asserted while RECOVER and FIFO holds 3 entries -> next cycle FIFO empty, FSM=RUN, counters 0, no pulses.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: in-flight prediction record,
// recovery FSM states and the delay-slot fall-through offset.
package branch_resolve_unit_pkg;

  localparam logic [31:0] DELAY_SLOT_OFS = 32'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_rec_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-flight prediction FIFO. Pointers carry an extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module bru_pred_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  pred_rec_t din,
  output logic      full,
  output logic      empty,
  output pred_rec_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  pred_rec_t   mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head  = mem_r[rd_ptr_r[AW-1:0]];

  // A push while full is accepted only when the head leaves in the same cycle.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | pop);

  // Pointer update; clear dominates push and pop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (do_push_s && !clear) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks ID-stage predictions against MEM-stage outcomes, trains the
// predictor and issues a fetch redirect plus wrong-path drain on mispredicts.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_push,
  input  logic [31:0] id_pc,
  input  logic        id_bp_result,
  input  logic [31:0] id_bp_addr,
  input  logic        mem_resolve,
  input  logic [31:0] mem_pc,
  input  logic        mem_taken,
  input  logic [31:0] mem_target,
  output logic        bru_full,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic        upd_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt,
  output logic        err_sticky
);

  localparam int CW = $clog2(RECOVER_CYC + 1);
  localparam logic [CW-1:0] REC_LAST = CW'(RECOVER_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  bru_state_e  state_r;
  logic [CW-1:0] rec_cnt_r;

  logic        fifo_full_s;
  logic        fifo_empty_s;
  pred_rec_t   head_s;
  pred_rec_t   push_rec_s;
  logic        use_head_s;
  logic        pred_taken_s;
  logic [31:0] pred_target_s;
  logic        mispred_s;
  logic        pc_err_s;
  logic        push_en_s;
  logic        drop_err_s;
  logic [31:0] correct_pc_s;

  bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_en_s),
    .pop   (use_head_s),
    .clear (mispred_s),
    .din   (push_rec_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (head_s)
  );

  assign bru_full = fifo_full_s;

  // Prediction compare; an absent head reads as predicted not-taken to 0.
  always_comb begin
    push_rec_s    = '{pc: id_pc, pred_taken: id_bp_result, pred_target: id_bp_addr};
    use_head_s    = mem_resolve & ~fifo_empty_s & (state_r == RUN);
    pred_taken_s  = 1'b0;
    pred_target_s = 32'd0;
    if (use_head_s) begin
      pred_taken_s  = head_s.pred_taken;
      pred_target_s = head_s.pred_target;
    end else begin
      pred_taken_s  = 1'b0;
      pred_target_s = 32'd0;
    end
    mispred_s    = mem_resolve & ((mem_taken != pred_taken_s) |
                   (mem_taken & pred_taken_s & (mem_target != pred_target_s)));
    pc_err_s     = use_head_s & (head_s.pc != mem_pc);
    push_en_s    = id_push & (state_r == RUN) & ~mispred_s;
    drop_err_s   = push_en_s & fifo_full_s & ~mem_resolve;
    correct_pc_s = mem_taken ? mem_target : (mem_pc + DELAY_SLOT_OFS);
  end

  // Registered training, redirect, counters and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid      <= 1'b0;
      upd_pc         <= 32'd0;
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      branch_cnt     <= 32'd0;
      mispred_cnt    <= 32'd0;
      err_sticky     <= 1'b0;
    end else begin
      upd_valid      <= mem_resolve;
      redirect_valid <= mispred_s;
      if (mem_resolve) begin
        upd_pc     <= mem_pc;
        upd_taken  <= mem_taken;
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (mispred_s) begin
        redirect_pc <= correct_pc_s;
        mispred_cnt <= mispred_cnt + 32'd1;
      end
      if (pc_err_s || drop_err_s) begin
        err_sticky <= 1'b1;
      end
    end
  end

  // Recovery FSM: a mispredict (re)starts the wrong-path drain window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= RUN;
      rec_cnt_r <= '0;
    end else begin
      case (state_r)
        RUN: begin
          if (mispred_s) begin
            state_r   <= RECOVER;
            rec_cnt_r <= '0;
          end
        end
        RECOVER: begin
          if (mispred_s) begin
            rec_cnt_r <= '0;
          end else if (rec_cnt_r == REC_LAST) begin
            state_r   <= RUN;
            rec_cnt_r <= '0;
          end else begin
            rec_cnt_r <= rec_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= RUN;
          rec_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: a queue-based reference model predicts each resolve's
// response; a negedge monitor pops and compares whenever the DUT strobes.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int REC   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, id_push, id_bp_result, mem_resolve, mem_taken;
  logic [31:0] id_pc, id_bp_addr, mem_pc, mem_target;
  logic        bru_full, upd_valid, upd_taken, redirect_valid, err_sticky;
  logic [31:0] upd_pc, redirect_pc, branch_cnt, mispred_cnt;

  branch_resolve_unit #(.DEPTH(DEPTH), .RECOVER_CYC(REC)) dut (
    .clk(clk), .reset(reset),
    .id_push(id_push), .id_pc(id_pc), .id_bp_result(id_bp_result), .id_bp_addr(id_bp_addr),
    .mem_resolve(mem_resolve), .mem_pc(mem_pc), .mem_taken(mem_taken), .mem_target(mem_target),
    .bru_full(bru_full), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .err_sticky(err_sticky)
  );

  typedef struct {
    logic [31:0] pc;
    logic        t;
    logic [31:0] tg;
  } rec_t;

  typedef struct {
    logic [31:0] pc;
    logic        t;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  bit   started = 1'b0;
  bit   done = 1'b0;
  rec_t mq[$];
  exp_t sb[$];
  int   rec_left = 0;
  logic [31:0] m_bc = 32'd0, m_mc = 32'd0, m_rpc = 32'd0;
  logic m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: one clock edge worth of behaviour.
  task automatic model_step(input logic rst, psh, input logic [31:0] pc, input logic bt,
                            input logic [31:0] ba, input logic res, input logic [31:0] mpc,
                            input logic mt, input logic [31:0] mtg,
                            output bit have, output exp_t e);
    rec_t h;
    bit   mis;
    have = 1'b0;
    mis  = 1'b0;
    h    = '{32'd0, 1'b0, 32'd0};
    e    = '{32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
    if (rst) begin
      mq.delete();
      rec_left = 0;
      m_bc = 32'd0; m_mc = 32'd0; m_rpc = 32'd0; m_err = 1'b0;
    end else begin
      if (res && rec_left == 0 && mq.size() > 0) begin
        h = mq.pop_front();
        if (h.pc != mpc) m_err = 1'b1;
      end
      if (res) begin
        mis  = (mt != h.t) || (mt && h.t && mtg != h.tg);
        m_bc = m_bc + 32'd1;
        if (mis) begin
          m_mc  = m_mc + 32'd1;
          m_rpc = mt ? mtg : mpc + 32'd8;
        end
        have = 1'b1;
        e    = '{mpc, mt, mis, m_rpc, m_bc, m_mc};
      end
      if (psh && rec_left == 0 && !mis) begin
        if (mq.size() < DEPTH) mq.push_back('{pc, bt, ba});
        else m_err = 1'b1;
      end
      if (mis) begin
        mq.delete();
        rec_left = REC;
      end else if (rec_left > 0) begin
        rec_left--;
      end
    end
  endtask

  task automatic cyc(input logic rst, psh, input logic [31:0] pc, input logic bt,
                     input logic [31:0] ba, input logic res, input logic [31:0] mpc,
                     input logic mt, input logic [31:0] mtg);
    bit   have;
    exp_t e;
    reset = rst; id_push = psh; id_pc = pc; id_bp_result = bt; id_bp_addr = ba;
    mem_resolve = res; mem_pc = mpc; mem_taken = mt; mem_target = mtg;
    if (started) begin
      chk("bru_full", bru_full, (mq.size() == DEPTH));
      chk("err_sticky", err_sticky, m_err);
      chk("branch_cnt", branch_cnt, m_bc);
      chk("mispred_cnt", mispred_cnt, m_mc);
    end
    model_step(rst, psh, pc, bt, ba, res, mpc, mt, mtg, have, e);
    @(posedge clk);
    if (have) sb.push_back(e);
    #1;
  endtask

  task automatic push_b(input logic [31:0] pc, input logic bt, input logic [31:0] ba);
    cyc(1'b0, 1'b1, pc, bt, ba, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic resolve(input logic [31:0] mpc, input logic mt, input logic [31:0] mtg);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, mpc, mt, mtg);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Monitor: whenever the DUT strobes, pop the oldest expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    if (started && !done) begin
      chk("upd_valid", upd_valid, (sb.size() != 0));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("upd_pc", upd_pc, e.pc);
        chk("upd_taken", upd_taken, e.t);
        chk("redirect_valid", redirect_valid, e.rv);
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("resp_branch_cnt", branch_cnt, e.bc);
        chk("resp_mispred_cnt", mispred_cnt, e.mc);
      end else begin
        chk("redirect_idle", redirect_valid, 1'b0);
      end
    end
  end

  initial begin
    logic [31:0] pc, ba, mpc, mtg;
    logic        psh, bt, res, mt, rst;

    do_reset();
    started = 1'b1;
    idle();

    // Correct taken prediction.
    push_b(32'h100, 1'b1, 32'h200);
    resolve(32'h100, 1'b1, 32'h200);
    idle();

    // Predicted not-taken, actually taken; pushes during drain ignored.
    push_b(32'h100, 1'b0, 32'h0);
    resolve(32'h100, 1'b1, 32'h300);
    push_b(32'h500, 1'b1, 32'h600);
    push_b(32'h504, 1'b1, 32'h600);
    push_b(32'h700, 1'b1, 32'h800);
    resolve(32'h700, 1'b1, 32'h800);

    // Taken predicted, not taken actual; then wrong-target.
    push_b(32'h100, 1'b1, 32'h200);
    resolve(32'h100, 1'b0, 32'h0);
    idle(); idle();
    push_b(32'h100, 1'b1, 32'h200);
    resolve(32'h100, 1'b1, 32'h204);
    idle(); idle();

    // Fill, overflow drop, push-with-pop on full, drain.
    for (int i = 0; i < 4; i++) push_b(32'h1000 + 32'(i * 4), 1'b1, 32'h1040 + 32'(i * 4));
    push_b(32'h2000, 1'b1, 32'h2040);
    cyc(1'b0, 1'b1, 32'h2004, 1'b1, 32'h2044, 1'b1, 32'h1000, 1'b1, 32'h1040);
    for (int i = 1; i < 4; i++) resolve(32'h1000 + 32'(i * 4), 1'b1, 32'h1040 + 32'(i * 4));
    resolve(32'h2004, 1'b1, 32'h2044);

    // Resolve on empty FIFO.
    resolve(32'h400, 1'b1, 32'h40);
    idle(); idle();
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
    idle();

    // Reset with entries in flight, and reset during recovery with a mispredict.
    for (int i = 0; i < 3; i++) push_b(32'h3000 + 32'(i * 4), 1'b0, 32'h0);
    do_reset();
    idle();
    push_b(32'h100, 1'b0, 32'h0);
    resolve(32'h100, 1'b1, 32'h300);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h900, 1'b1, 32'h980);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      psh = $urandom_range(0, 1);
      pc  = $urandom() & 32'hFFFF_FFFC;
      bt  = $urandom_range(0, 1);
      ba  = ($urandom_range(0, 3) == 0) ? $urandom() : pc + 32'h80;
      res = ($urandom_range(0, 2) == 0);
      mt  = $urandom_range(0, 1);
      if (mq.size() > 0 && $urandom_range(0, 7) != 0) mpc = mq[0].pc;
      else mpc = $urandom();
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) mtg = mq[0].tg;
      else mtg = $urandom();
      cyc(rst, psh, pc, bt, ba, res, mpc, mt, mtg);
    end

    idle(); idle();
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
